// File: rtl/prog_loader.sv
// Streams a length-prefixed, XOR-checksummed program image into program memory
// and holds the CPU in reset until a complete, verified image has been written.
module prog_loader #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned BASE    = 0,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              write,
    output logic [ADDR_W-1:0] writeaddr,
    output logic [7:0]        writevalue,
    output logic              cpu_rst,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   byte_count
);

    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_PAYLOAD,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic [7:0]        len_lo;
    logic [15:0]       len;
    logic [15:0]       frame_len;
    logic [7:0]        csum;
    logic [IDLE_W-1:0] idle;
    logic              idle_expired;
    logic              last_payload;
    logic              in_frame;

    assign accept       = in_valid & in_ready;
    assign frame_len    = {in_data, len_lo};
    assign last_payload = (32'(byte_count) + 32'd1) == 32'(len);
    assign in_frame     = (state == S_LEN_HI) || (state == S_PAYLOAD) || (state == S_CHECK);
    // The idle count reaches TIMEOUT on this edge if no byte arrives.
    assign idle_expired = (TIMEOUT != 0) && !accept && ((32'(idle) + 32'd1) >= TIMEOUT);

    always_comb begin
        state_next = state;
        case (state)
            S_LEN_LO: begin
                if (accept) state_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (accept) begin
                    if (frame_len == 16'd0)             state_next = S_CHECK;
                    else if (32'(frame_len) > DEPTH)    state_next = S_ERROR;
                    else                                state_next = S_PAYLOAD;
                end else if (idle_expired) begin
                    state_next = S_ERROR;
                end
            end
            S_PAYLOAD: begin
                if (accept) begin
                    if (last_payload) state_next = S_CHECK;
                end else if (idle_expired) begin
                    state_next = S_ERROR;
                end
            end
            S_CHECK: begin
                if (accept)            state_next = (in_data == csum) ? S_DONE : S_ERROR;
                else if (idle_expired) state_next = S_ERROR;
            end
            S_DONE, S_ERROR: begin
                if (reload) state_next = S_LEN_LO;
            end
            default: state_next = S_LEN_LO;
        endcase
    end

    // State register; status outputs are registered from the next state so they
    // change on the same edge as the state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_LEN_LO;
            in_ready <= 1'b1;
            cpu_rst  <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            state    <= state_next;
            in_ready <= (state_next != S_DONE) && (state_next != S_ERROR);
            cpu_rst  <= (state_next != S_DONE);
            done     <= (state_next == S_DONE);
            error    <= (state_next == S_ERROR);
        end
    end

    // Frame datapath: length capture, memory write port, checksum, idle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_lo     <= 8'd0;
            len        <= 16'd0;
            csum       <= 8'd0;
            idle       <= '0;
            byte_count <= '0;
            write      <= 1'b0;
            writeaddr  <= '0;
            writevalue <= 8'd0;
        end else begin
            write <= 1'b0;
            if (state == S_LEN_LO && accept) len_lo <= in_data;
            if (state == S_LEN_HI && accept) len    <= frame_len;
            if (state == S_PAYLOAD && accept) begin
                write      <= 1'b1;
                writevalue <= in_data;
                writeaddr  <= ADDR_W'(BASE + 32'(byte_count));
                byte_count <= byte_count + (ADDR_W + 1)'(1);
                csum       <= csum ^ in_data;
            end
            if ((state == S_DONE || state == S_ERROR) && reload) begin
                csum       <= 8'd0;
                byte_count <= '0;
            end
            if (accept || state_next != state)     idle <= '0;
            else if (in_frame && TIMEOUT != 0)     idle <= idle + IDLE_W'(1);
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboarded bench for prog_loader: two instances (BASE=0/TIMEOUT=10 and
// BASE=0xFE/timeout disabled) driven with directed frames.
module tb_prog_loader;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       vld [2];
    logic [7:0] dat [2];
    logic       rld [2];
    logic       rdy [2];
    logic       wr  [2];
    logic [7:0] wa  [2];
    logic [7:0] wv  [2];
    logic       cpu [2];
    logic       dn  [2];
    logic       er  [2];
    logic [8:0] bc  [2];

    exp_t       q0[$];
    exp_t       q1[$];
    logic [7:0] stim[$];
    int         cyc   = 0;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    prog_loader #(.ADDR_W(8), .BASE(0), .TIMEOUT(10)) dut0 (
        .clk(clk), .rst(rst), .in_valid(vld[0]), .in_data(dat[0]), .in_ready(rdy[0]),
        .reload(rld[0]), .write(wr[0]), .writeaddr(wa[0]), .writevalue(wv[0]),
        .cpu_rst(cpu[0]), .done(dn[0]), .error(er[0]), .byte_count(bc[0])
    );

    prog_loader #(.ADDR_W(8), .BASE(8'hFE), .TIMEOUT(0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(vld[1]), .in_data(dat[1]), .in_ready(rdy[1]),
        .reload(rld[1]), .write(wr[1]), .writeaddr(wa[1]), .writevalue(wv[1]),
        .cpu_rst(cpu[1]), .done(dn[1]), .error(er[1]), .byte_count(bc[1])
    );

    // Write monitors: every write pulse must match the oldest expected write,
    // including the cycle in which it appears.
    task automatic mon(input int s, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        n_vec++;
        if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
            n_err++;
            $display("FAIL write_d%0d unexpected write got addr=%h data=%h cyc=%0d required none",
                     s, a, d, cyc);
        end else begin
            e = (s == 0) ? q0.pop_front() : q1.pop_front();
            if (a !== e.addr || d !== e.data || cyc != e.cyc) begin
                n_err++;
                $display("FAIL write_d%0d got addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                         s, a, d, cyc, e.addr, e.data, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (wr[0] === 1'b1) mon(0, wa[0], wv[0]);
        if (wr[1] === 1'b1) mon(1, wa[1], wv[1]);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s got %0h required %0h", name, act, req);
        end
    endtask

    task automatic status(input int s, input int r, input int c, input int d, input int e, input int b);
        check($sformatf("d%0d_in_ready", s),   32'(rdy[s]), 32'(r));
        check($sformatf("d%0d_cpu_rst", s),    32'(cpu[s]), 32'(c));
        check($sformatf("d%0d_done", s),       32'(dn[s]),  32'(d));
        check($sformatf("d%0d_error", s),      32'(er[s]),  32'(e));
        check($sformatf("d%0d_byte_count", s), 32'(bc[s]),  32'(b));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends stim[] to instance s; stim[first..first+npay-1] are expected as
    // writes to addr0, addr0+1, ... one cycle after each accept.
    task automatic frame(input int s, input int first, input int npay, input logic [7:0] addr0,
                         input int gap);
        exp_t e;
        for (int i = 0; i < stim.size(); i++) begin
            vld[s] = 1'b1;
            dat[s] = stim[i];
            @(posedge clk);
            #1;
            if (i >= first && i < first + npay) begin
                e.addr = 8'(int'(addr0) + i - first);
                e.data = stim[i];
                e.cyc  = cyc;
                if (s == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
            vld[s] = 1'b0;
            idle(gap);
        end
    endtask

    task automatic do_reload(input int s);
        rld[s] = 1'b1;
        @(posedge clk);
        #1;
        rld[s] = 1'b0;
        status(s, 1, 1, 0, 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            vld[s] = 1'b0;
            dat[s] = 8'h00;
            rld[s] = 1'b0;
        end
        idle(2);
        rst = 1'b0;

        // Reset state
        status(0, 1, 1, 0, 0, 0);
        check("d0_write_rst", 32'(wr[0]), 0);
        check("d0_writeaddr_rst", 32'(wa[0]), 0);
        check("d0_writevalue_rst", 32'(wv[0]), 0);

        // Good 3-byte frame
        stim = '{8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        frame(0, 2, 3, 8'h00, 0);
        status(0, 0, 0, 1, 0, 3);
        do_reload(0);

        // Bad checksum, then reload and a good frame
        stim = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h00};
        frame(0, 2, 2, 8'h00, 0);
        status(0, 0, 1, 0, 1, 2);
        do_reload(0);
        stim = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
        frame(0, 2, 2, 8'h00, 0);
        status(0, 0, 0, 1, 0, 2);
        do_reload(0);

        // Length 257 exceeds depth
        stim = '{8'h01, 8'h01};
        frame(0, 2, 0, 8'h00, 0);
        status(0, 0, 1, 0, 1, 0);
        do_reload(0);

        // Empty frame
        stim = '{8'h00, 8'h00, 8'h00};
        frame(0, 2, 0, 8'h00, 0);
        status(0, 0, 0, 1, 0, 0);
        do_reload(0);

        // in_valid toggling every other cycle, 5 payload bytes
        stim = '{8'h05, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h1F};
        frame(0, 2, 5, 8'h00, 1);
        status(0, 0, 0, 1, 0, 5);
        do_reload(0);

        // Timeout: 9 idle cycles tolerated, the 10th aborts
        stim = '{8'h02, 8'h00, 8'h5A};
        frame(0, 2, 1, 8'h00, 0);
        idle(9);
        status(0, 1, 1, 0, 0, 1);
        idle(1);
        status(0, 0, 1, 0, 1, 1);
        do_reload(0);

        // Reset mid-payload, then a good frame
        stim = '{8'h04, 8'h00, 8'h01, 8'h02};
        frame(0, 2, 2, 8'h00, 0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        status(0, 1, 1, 0, 0, 0);
        check("d0_write_midrst", 32'(wr[0]), 0);
        check("d0_writeaddr_midrst", 32'(wa[0]), 0);
        check("d0_writevalue_midrst", 32'(wv[0]), 0);
        stim = '{8'h01, 8'h00, 8'h77, 8'h77};
        frame(0, 2, 1, 8'h00, 0);
        status(0, 0, 0, 1, 0, 1);

        // BASE=0xFE wrap-around
        status(1, 1, 1, 0, 0, 0);
        stim = '{8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h00};
        frame(1, 2, 3, 8'hFE, 0);
        status(1, 0, 0, 1, 0, 3);
        do_reload(1);

        // Timeout disabled: long stall mid-frame is harmless
        stim = '{8'h02, 8'h00};
        frame(1, 2, 0, 8'hFE, 0);
        idle(50);
        status(1, 1, 1, 0, 0, 0);
        stim = '{8'h05, 8'h06, 8'h03};
        frame(1, 0, 2, 8'hFE, 0);
        status(1, 0, 0, 1, 0, 2);

        idle(4);
        check("d0_writes_outstanding", 32'(q0.size()), 0);
        check("d1_writes_outstanding", 32'(q1.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 8, program memory address width; memory depth DEPTH = 2**ADDR_W.
REQ-002 Parameter BASE, default 0, first program memory address written.
REQ-003 Parameter TIMEOUT, default 1000, maximum idle cycles between bytes inside a frame; 0 disables the timeout.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  source presents a byte on in_data.
REQ-007 in_data  input  8  stream byte.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 reload  input  1  single-cycle request to start a new load from DONE or ERROR.
REQ-010 write  output  1  program memory write strobe, one cycle per payload byte.
REQ-011 writeaddr  output  ADDR_W  program memory write address.
REQ-012 writevalue  output  8  program memory write data.
REQ-013 cpu_rst  output  1  active-high reset to the CPU; held asserted while no valid program is loaded.
REQ-014 done  output  1  program loaded and checksum correct.
REQ-015 error  output  1  frame rejected; the load must be repeated.
REQ-016 byte_count  output  ADDR_W+1  payload bytes written so far in the current frame.

Function
REQ-017 A byte is accepted on a rising clk edge where in_valid and in_ready are both 1; no other byte is consumed.
REQ-018 Frame format: length low byte, length high byte (16-bit little-endian N), then N payload bytes, then 1 checksum byte equal to the XOR of all payload bytes.
REQ-019 States: LEN_LO, LEN_HI, PAYLOAD, CHECK, DONE, ERROR.
REQ-020 in_ready is 1 in LEN_LO, LEN_HI, PAYLOAD and CHECK, and 0 in DONE and ERROR.
REQ-021 LEN_LO --accept--> LEN_HI; LEN_HI --accept--> PAYLOAD if 0 < N <= DEPTH, CHECK if N = 0, ERROR if N > DEPTH.
REQ-022 PAYLOAD: each accept registers the byte; the following cycle write=1, writevalue=byte, writeaddr=(BASE+index) mod DEPTH, where index counts from 0; after the N-th accept, go to CHECK.
REQ-023 write latency is exactly one cycle after the accept edge; back-to-back accepts produce back-to-back write pulses.
REQ-024 The running XOR is cleared on entry to LEN_LO and updated on every payload accept.
REQ-025 CHECK --accept--> DONE if the byte equals the running XOR, otherwise ERROR.
REQ-026 byte_count increments with each payload accept and is cleared on entry to LEN_LO.
REQ-027 cpu_rst = 1 in every state except DONE; done = 1 only in DONE; error = 1 only in ERROR.
REQ-028 On the DONE entry edge, cpu_rst deasserts on the same edge on which done asserts; the final write pulse completes before done rises.
REQ-029 In LEN_HI, PAYLOAD and CHECK, with TIMEOUT > 0: an idle counter increments each cycle without an accept and clears on every accept. When it reaches TIMEOUT, go to ERROR.
REQ-030 LEN_LO has no timeout.
REQ-031 reload=1 in DONE or ERROR: go to LEN_LO, assert cpu_rst the next cycle, and clear done and error.
REQ-032 reload is ignored in all other states.
REQ-033 Memory content from an aborted or failed frame is not erased; cpu_rst stays asserted until a good frame completes.

Reset
REQ-034 rst=1 at a clk edge forces LEN_LO regardless of state, including mid-frame.
REQ-035 After reset: in_ready=1, write=0, writeaddr=0, writevalue=0, cpu_rst=1, done=0, error=0, byte_count=0, checksum=0, idle counter=0.
REQ-036 rst takes priority over reload, accepts and timeout.

Verification
REQ-037 Defaults, stream 03 00 AA BB CC DD -> writes AA@0, BB@1, CC@2, then done=1, cpu_rst=0, byte_count=3.
REQ-038 Stream 02 00 11 22 00 (bad checksum, expected 33) -> two writes, error=1, cpu_rst=1; then reload and a good frame -> done=1.
REQ-039 Stream 01 01 (N=257 > DEPTH=256) -> ERROR after the 2nd byte, no write pulse.
REQ-040 Stream 00 00 00 -> DONE with zero writes; BASE=0xFE with stream 03 00 01 02 03 00 -> addresses FE, FF, 00 (wrap-around).
REQ-041 TIMEOUT=10, stall 10 cycles after the 1st payload byte -> ERROR; rst asserted mid-PAYLOAD -> LEN_LO, all outputs at reset values next cycle.
REQ-042 in_valid toggling every other cycle, payload 5 bytes -> exactly 5 one-cycle write pulses, each one cycle after its accept.
